delay_buffer: RTL and testbench
===============================

Name: delay_buffer

Overview:
Parametrised successor to the single-bit, single-cycle registered buffer. Delays a WIDTH-bit data word plus a valid flag through a DEPTH-stage shift pipeline. Adds clock enable (stall), flush, a selectable output tap and an occupancy counter. Used as a generic pipeline delay and re-alignment element between datapath stages.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of register stages (>=1)
TAP_W, (DEPTH>1 ? $clog2(DEPTH) : 1), tap_sel width; derived localparam, not overridden
CNT_W, $clog2(DEPTH+1), occupancy counter width; derived localparam

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
en  input  1  advance enable; 0 = hold all stages (stall)
flush  input  1  synchronous clear of all stages
in_valid  input  1  input word qualifier
in  input  WIDTH  input data word
tap_sel  input  TAP_W  output tap; delay = tap_sel+1 enabled cycles (DELAY_BUFFER_TAP_EN only)
out  output  WIDTH  data at selected tap
out_valid  output  1  valid at selected tap
count  output  CNT_W  number of valid entries across all stages
busy  output  1  count != 0

Behaviour:
- Storage: stage s[0..DEPTH-1], each {v, d}. All state changes occur on the rising edge of clk only.
- Reset (rst_n=0 at an edge): every s[i].v=0 and s[i].d=0; count=0. Outputs out=0, out_valid=0, busy=0 from the first edge with rst_n=0. Reset overrides flush and en, including in the middle of operation.
- Priority: rst_n > flush > en.
- flush=1: every s[i].v=0 and s[i].d=0; count=0. The input on this cycle is dropped, even when en=1.
- en=1 (no flush): s[0] <= {in_valid, in}. s[i] <= s[i-1] for i>=1. The entry leaving s[DEPTH-1] is discarded.
- en=1 with in_valid=0: a bubble enters. Its data is still captured into s[0].d, but downstream consumers must qualify data with out_valid.
- en=0 (no flush): all stages hold. count holds.
- count update on an en cycle: count <= count + in_valid - s[DEPTH-1].v. The result never exceeds DEPTH and never goes negative.
- Output is combinational from the registers only; there is no in→out combinational path. {out_valid, out} = s[k], where k is the selected tap.
- Latency: a word presented with en=1 appears at out after k+1 rising edges on which en=1. Stalled edges do not count.
- DEPTH=1, en tied high, flush=0: out is in delayed by exactly one clock, matching the original buffer.
- busy = (count != 0). It is combinational from count.

Optional Feature:
DELAY_BUFFER_TAP_EN
- Defined: k = tap_sel. If tap_sel > DEPTH-1 (DEPTH not a power of 2), k clamps to DEPTH-1. tap_sel may change on any cycle; out switches to the new tap in the same cycle, with no change to stored state.
- Undefined: k = DEPTH-1 (fixed full delay). The tap_sel port still exists and is ignored. No tap multiplexer is synthesised.
- count and busy always cover all DEPTH stages, regardless of the tap.

Decomposition:
- Shared package delay_buffer_pkg holds:
  - a clog2-safe width function used for TAP_W and CNT_W;
  - a typedef or macro for the stage record {v, d}.
- One sub-module, delay_stage: a single {v, d} register with synchronous active-low reset, en and flush. Generate DEPTH instances in a chain.
- Tap mux, counter and busy logic live in the top level.

Test Plan:
- WIDTH=1, DEPTH=1, en=1, in_valid=1, rst_n released at t=0; in=0,1,0,1 changed every 10ns (clk period 10ns) → out=0,0,1,0,1 lagging in by one edge; out_valid=1 from the 2nd edge.
- WIDTH=8, DEPTH=4, tap fixed: push 0x11,0x22,0x33,0x44,0x55 with en=1 → out=0x11 on edge 4, 0x55 on edge 8. count=1,2,3,4,4, then stays 4.
- Same configuration, en=0 for 3 cycles after 0x22 enters → out, count and busy frozen. Once resumed, 0x11 reaches out after 4 total enabled edges.
- flush=1 and en=1 with in=0xAA, in_valid=1, when count=3 → next edge count=0, out_valid=0, out=0, busy=0. 0xAA never appears.
- DELAY_BUFFER_TAP_EN, DEPTH=5, tap_sel=1: push 0x01 → out=0x01 after 2 edges. Switch tap_sel to 4 → out shows s[4] immediately. tap_sel=7 → clamps to 4.
- rst_n=0 asserted mid-stream with count=4 and en=1 → on that edge all outputs=0 and count=0. Stalled data is lost. No output at rst_n deassertion before the first enabled edge.

Source files
------------

// File: rtl/delay_buffer_pkg.sv
// delay_buffer_pkg: shared width helper and stage record for delay_buffer.
`ifndef DELAY_BUFFER_PKG_SV
`define DELAY_BUFFER_PKG_SV
`define DELAY_BUFFER_STAGE_T(W) struct packed {logic v; logic [(W)-1:0] d;}
package delay_buffer_pkg;
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage
`endif

// File: rtl/delay_stage.sv
// delay_stage: one {v, d} pipeline register with stall and flush.
module delay_stage #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           flush,
  input  logic [WIDTH:0] s_i,
  output logic [WIDTH:0] s_o
);
  logic [WIDTH:0] s_q, s_d;
  always_comb s_d = flush ? '0 : en ? s_i : s_q;
  always_ff @(posedge clk) begin
    if (!rst_n) s_q <= '0;
    else s_q <= s_d;
  end
  assign s_o = s_q;
endmodule

// File: rtl/delay_buffer.sv
// delay_buffer: DEPTH-stage data/valid delay line with stall, flush and occupancy count.
// Define DELAY_BUFFER_TAP_EN to make the output tap selectable via tap_sel.
module delay_buffer
  import delay_buffer_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int TAP_W = safe_clog2(DEPTH),
  localparam int CNT_W = safe_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [CNT_W-1:0] count,
  output logic             busy
);
  typedef `DELAY_BUFFER_STAGE_T(WIDTH) stage_t;
  stage_t s [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      stage_t s_in;
      if (g == 0) begin : g_head
        assign s_in = {in_valid, in};
      end else begin : g_link
        assign s_in = s[g-1];
      end
      delay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .flush(flush),
        .s_i  (s_in),
        .s_o  (s[g])
      );
    end
  endgenerate
  // Entry leaving the last stage is the only one that can reduce occupancy.
  always_comb cnt_d = flush ? '0 : en ? cnt_q + CNT_W'(in_valid) - CNT_W'(s[DEPTH-1].v) : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign count = cnt_q;
  assign busy  = cnt_q != '0;
`ifdef DELAY_BUFFER_TAP_EN
  logic [TAP_W-1:0] k;
  assign k = (tap_sel > TAP_W'(DEPTH - 1)) ? TAP_W'(DEPTH - 1) : tap_sel;
  assign out_valid = s[k].v;
  assign out       = s[k].d;
`else
  logic unused_tap;
  assign unused_tap = ^tap_sel;
  assign out_valid  = s[DEPTH-1].v;
  assign out        = s[DEPTH-1].d;
`endif
endmodule

// File: tb/tb_delay_buffer.sv
// tb_delay_buffer: directed self-checking bench for delay_buffer.
module tb_delay_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int passed = 0;
  logic       rst_n, en, flush, in_valid;
  logic [7:0] din, out;
  logic [1:0] tap;
  logic       out_valid, busy;
  logic [2:0] count;
  logic       in1, out1, out_valid1, busy1, count1;
  logic       tap1;
  delay_buffer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid), .in(din),
    .tap_sel(tap), .out(out), .out_valid(out_valid), .count(count), .busy(busy)
  );
  delay_buffer #(.WIDTH(1), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .flush(1'b0), .in_valid(1'b1), .in(in1),
    .tap_sel(tap1), .out(out1), .out_valid(out_valid1), .count(count1), .busy(busy1)
  );
`ifdef DELAY_BUFFER_TAP_EN
  logic       en_t, v_t, out_valid_t, busy_t;
  logic [7:0] in_t, out_t;
  logic [2:0] tap_t, count_t;
  delay_buffer #(.WIDTH(8), .DEPTH(5)) dut_t (
    .clk(clk), .rst_n(rst_n), .en(en_t), .flush(1'b0), .in_valid(v_t), .in(in_t),
    .tap_sel(tap_t), .out(out_t), .out_valid(out_valid_t), .count(count_t), .busy(busy_t)
  );
`endif
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  initial begin
    rst_n = 0; en = 1; flush = 0; in_valid = 0; din = 0; tap = 2'd3; in1 = 0; tap1 = 0;
`ifdef DELAY_BUFFER_TAP_EN
    en_t = 0; v_t = 0; in_t = 0; tap_t = 0;
`endif
    tick();
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid1", out_valid1, 0);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      din = 8'(8'h11 * (i + 1)); in_valid = 1; in1 = i[0];
      tick();
      chk("fill_count", count, (i < 3) ? i + 1 : 4);
      chk("fill_valid", out_valid, i >= 3);
      if (i >= 3) chk("fill_out", out, 8'h11 * (i - 2));
      chk("d1_out", out1, i[0]);
      chk("d1_valid", out_valid1, 1);
    end
    rst_n = 0; tick(); rst_n = 1;
    din = 8'h11; tick();
    din = 8'h22; tick();
    en = 0; din = 8'h33;
    repeat (3) begin
      tick();
      chk("stall_count", count, 2);
      chk("stall_busy", busy, 1);
      chk("stall_valid", out_valid, 0);
    end
    en = 1; din = 8'h33; tick();
    din = 8'h44; tick();
    chk("resume_out", out, 8'h11);
    chk("resume_valid", out_valid, 1);
    chk("resume_count", count, 4);
    rst_n = 0; din = 8'h99;
    tick();
    chk("mrst_out", out, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_count", count, 0);
    chk("mrst_busy", busy, 0);
    rst_n = 1; en = 0;
    tick(); tick();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_count", count, 0);
    en = 1;
    din = 8'h11; tick();
    din = 8'h22; tick();
    din = 8'h33; tick();
    chk("pre_flush_count", count, 3);
    flush = 1; din = 8'hAA;
    tick();
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_out", out, 0);
    chk("flush_busy", busy, 0);
    flush = 0; in_valid = 0; din = 0;
    repeat (4) begin
      tick();
      chk("drain_valid", out_valid, 0);
      chk("drain_out", out, 0);
    end
`ifdef DELAY_BUFFER_TAP_EN
    en_t = 1; v_t = 1; in_t = 8'h01; tap_t = 3'd1;
    tick();
    chk("tap1_early", out_valid_t, 0);
    v_t = 0; in_t = 0;
    tick();
    chk("tap1_out", out_t, 8'h01);
    chk("tap1_valid", out_valid_t, 1);
    tap_t = 3'd4; #1;
    chk("tap4_valid_empty", out_valid_t, 0);
    tick(); tick(); tick();
    chk("tap4_out", out_t, 8'h01);
    chk("tap4_valid", out_valid_t, 1);
    chk("tap_count", count_t, 1);
    tap_t = 3'd7; #1;
    chk("tap7_clamp", out_t, 8'h01);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
